// File: rtl/mic_delay_engine.sv
// Channel-serial per-channel integer-sample delay over one shared circular buffer, with staged/committed delay tables.
// Optional macro DELAY_SUM_EN adds sum_out, the signed sum of all delayed lanes.
module mic_delay_engine #(
  parameter int CHANNELS  = 16,
  parameter int DATA_W    = 19,
  parameter int MAX_DELAY = 63,
  localparam int DELAY_W  = $clog2(MAX_DELAY + 1),
  localparam int DEPTH    = 2 ** DELAY_W,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   pcm_in,
  input  logic                         pcm_valid,
  output logic                         in_ready,
  output logic                         overrun,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [DELAY_W:0]             cfg_delay,
  input  logic                         cfg_commit,
  output logic                         commit_pending,
  output logic [CHANNELS*DATA_W-1:0]   pcm_out,
  output logic                         out_valid
`ifdef DELAY_SUM_EN
  ,
  output logic signed [DATA_W+CH_W-1:0] sum_out
`endif
);

  localparam int AW = CH_W + DELAY_W;
  localparam int FW = CHANNELS * DATA_W;
  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

  typedef enum logic [1:0] {IDLE, PROC, EMIT} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]  mem [CHANNELS*DEPTH];
  logic [DATA_W-1:0]  rd_dat;
  logic [FW-1:0]      in_buf;
  logic [FW-1:0]      lane_buf;
  logic [FW-1:0]      lanes_next;
  logic [DELAY_W-1:0] staged [CHANNELS];
  logic [DELAY_W-1:0] active [CHANNELS];
  logic [DELAY_W-1:0] wp;
  logic [DELAY_W-1:0] frame_cnt;
  logic [CH_W-1:0]    ch;

  // One-cycle pipeline carrying per-channel decisions to the RAM read return.
  logic               p_vld;
  logic               p_zero;
  logic               p_bypass;
  logic [CH_W-1:0]    p_ch;
  logic [DATA_W-1:0]  p_sample;

  logic               accept;
  logic [DELAY_W-1:0] cur_d;
  logic [DELAY_W-1:0] rd_off;
  logic [DATA_W-1:0]  cur_sample;
  logic [DATA_W-1:0]  lane_val;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic [CH_W:0]      cfg_ch_ext;
  logic               cfg_ok;
  logic [DELAY_W-1:0] cfg_clamped;

  assign accept      = (state_q == IDLE) && pcm_valid;
  assign cur_d       = active[ch];
  assign rd_off      = wp - cur_d;
  assign cur_sample  = in_buf[ch*DATA_W +: DATA_W];
  assign wr_addr     = {ch, wp};
  assign rd_addr     = {ch, rd_off};
  assign lane_val    = p_zero ? '0 : (p_bypass ? p_sample : rd_dat);
  assign cfg_ch_ext  = {1'b0, cfg_ch};
  assign cfg_ok      = cfg_ch_ext < (CH_W+1)'(CHANNELS);
  assign cfg_clamped = (cfg_delay > (DELAY_W+1)'(MAX_DELAY)) ? MAX_D : cfg_delay[DELAY_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (pcm_valid) state_d = PROC;
      end
      PROC:    if (ch == CH_W'(CHANNELS - 1)) state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample RAM: contents are never cleared; unwritten history is masked by frame_cnt.
  always_ff @(posedge clk) begin
    if (state_q == PROC) begin
      mem[wr_addr] <= cur_sample;
      rd_dat       <= mem[rd_addr];
    end
  end

  always_comb begin
    lanes_next = lane_buf;
    if (p_vld) lanes_next[p_ch*DATA_W +: DATA_W] = lane_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_buf         <= '0;
      lane_buf       <= '0;
      pcm_out        <= '0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
      commit_pending <= 1'b0;
      wp             <= '0;
      frame_cnt      <= '0;
      ch             <= '0;
      p_vld          <= 1'b0;
      p_zero         <= 1'b0;
      p_bypass       <= 1'b0;
      p_ch           <= '0;
      p_sample       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        staged[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= pcm_valid && (state_q != IDLE);
      lane_buf  <= lanes_next;
      p_vld     <= (state_q == PROC);
      p_ch      <= ch;
      p_zero    <= cur_d > frame_cnt;
      p_bypass  <= (cur_d == '0);
      p_sample  <= cur_sample;

      if (cfg_we && cfg_ok) staged[cfg_ch] <= cfg_clamped;

      // The table swap happens only at frame acceptance, so one frame never mixes tables.
      if (accept && commit_pending) begin
        for (int i = 0; i < CHANNELS; i++) active[i] <= staged[i];
      end
      if (cfg_commit)  commit_pending <= 1'b1;
      else if (accept) commit_pending <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            in_buf <= pcm_in;
            ch     <= '0;
          end
        end
        PROC: ch <= ch + 1'b1;
        EMIT: begin
          pcm_out   <= lanes_next;
          out_valid <= 1'b1;
          wp        <= wp + 1'b1;
          if (frame_cnt != MAX_D) frame_cnt <= frame_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DELAY_SUM_EN
  localparam int SUM_W = DATA_W + CH_W;
  logic signed [SUM_W-1:0] acc_q;
  logic signed [SUM_W-1:0] acc_next;

  always_comb begin
    acc_next = acc_q;
    if (p_vld) acc_next = acc_q + $signed({{CH_W{lane_val[DATA_W-1]}}, lane_val});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      sum_out <= '0;
    end else begin
      if (accept) acc_q <= '0;
      else        acc_q <= acc_next;
      if (state_q == EMIT) sum_out <= acc_next;
    end
  end
`endif

endmodule

// File: tb/tb_mic_delay_engine.sv
// Randomized scoreboard bench for mic_delay_engine with a frame-history reference model.
module tb_mic_delay_engine;
  localparam int CHANNELS  = 16;
  localparam int DATA_W    = 19;
  localparam int MAX_DELAY = 63;
  localparam int DELAY_W   = 6;
  localparam int CH_W      = 4;
  localparam int FW        = CHANNELS * DATA_W;
  localparam int SUM_W     = DATA_W + CH_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [FW-1:0]     pcm_in;
  logic              pcm_valid;
  logic              in_ready;
  logic              overrun;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DELAY_W:0]  cfg_delay;
  logic              cfg_commit;
  logic              commit_pending;
  logic [FW-1:0]     pcm_out;
  logic              out_valid;
`ifdef DELAY_SUM_EN
  logic signed [SUM_W-1:0] sum_out;
`endif

  always #5 clk = ~clk;

  mic_delay_engine #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY)) dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .in_ready(in_ready),
    .overrun(overrun), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending), .pcm_out(pcm_out),
    .out_valid(out_valid)
`ifdef DELAY_SUM_EN
    , .sum_out(sum_out)
`endif
  );

  typedef struct {
    logic [FW-1:0] dat;
    longint        sum;
    int            at;
  } exp_t;

  exp_t          exp_q[$];
  int            ovr_q[$];
  logic [FW-1:0] hist[$];
  int            staged_m[CHANNELS];
  int            active_m[CHANNELS];
  bit            pending_m;
  int            free_edge;
  int            edge_n;
  logic [FW-1:0] hold_m;
  bit            mon_en;
  exp_t          mon_e;
  int            checks;
  int            failures;

  function automatic void chk(string name, logic [FW-1:0] act, logic [FW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, expv);
    end
  endfunction

  // Reference: every accepted frame is kept; lane c of frame n is frame n-d of history.
  function automatic void model_edge();
    exp_t          e;
    logic [FW-1:0] old;
    logic [DATA_W-1:0] v;
    logic signed [DATA_W-1:0] sv;
    int n;
    int d;
    if (!rst) begin
      exp_q.delete();
      ovr_q.delete();
      hist.delete();
      for (int c = 0; c < CHANNELS; c++) begin
        staged_m[c] = 0;
        active_m[c] = 0;
      end
      pending_m = 0;
      free_edge = 0;
      hold_m    = '0;
      return;
    end
    if (pcm_valid) begin
      if (edge_n >= free_edge) begin
        if (pending_m) begin
          active_m  = staged_m;
          pending_m = 0;
        end
        n     = hist.size();
        e.dat = '0;
        e.sum = 0;
        for (int c = 0; c < CHANNELS; c++) begin
          d = active_m[c];
          if (d == 0) v = pcm_in[c*DATA_W +: DATA_W];
          else if (d > n) v = '0;
          else begin
            old = hist[n-d];
            v   = old[c*DATA_W +: DATA_W];
          end
          e.dat[c*DATA_W +: DATA_W] = v;
          sv    = v;
          e.sum = e.sum + longint'(sv);
        end
        hist.push_back(pcm_in);
        e.at      = edge_n + CHANNELS + 1;
        free_edge = edge_n + CHANNELS + 2;
        exp_q.push_back(e);
      end else begin
        ovr_q.push_back(edge_n);
      end
    end
    if (cfg_we && int'(cfg_ch) < CHANNELS)
      staged_m[cfg_ch] = (int'(cfg_delay) > MAX_DELAY) ? MAX_DELAY : int'(cfg_delay);
    if (cfg_commit) pending_m = 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    mon_en = 1;
    #1;
    pcm_valid  = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    int w = 0;
    while (edge_n + 1 < free_edge && w < 200) begin
      tick();
      w++;
    end
    pcm_in    = f;
    pcm_valid = 1'b1;
    tick();
  endtask

  task automatic stage(input int c, input int d);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(c);
    cfg_delay = (DELAY_W+1)'(d);
    tick();
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int c = 0; c < CHANNELS; c++) f[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    return f;
  endfunction

  function automatic logic [FW-1:0] const_frame(input int v);
    logic [FW-1:0] f;
    for (int c = 0; c < CHANNELS; c++) f[c*DATA_W +: DATA_W] = DATA_W'(v);
    return f;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_valid_unexpected got=1 exp=0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_cycle", FW'(edge_n), FW'(mon_e.at));
          chk("pcm_out", pcm_out, mon_e.dat);
          hold_m = mon_e.dat;
`ifdef DELAY_SUM_EN
          chk("sum_out", FW'($unsigned(sum_out)), FW'($unsigned(SUM_W'(mon_e.sum))));
`endif
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
          mon_e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL out_valid_timeout got=0 exp=1 due=%0d", mon_e.at);
        end
        chk("pcm_out_hold", pcm_out, hold_m);
      end
      chk("in_ready", FW'(in_ready), FW'(edge_n >= free_edge - 1));
      if (ovr_q.size() > 0 && ovr_q[0] == edge_n) begin
        void'(ovr_q.pop_front());
        chk("overrun", FW'(overrun), FW'(1));
      end else begin
        chk("overrun", FW'(overrun), FW'(0));
      end
      chk("commit_pending", FW'(commit_pending), FW'(pending_m));
    end
  end

  initial begin
    logic [FW-1:0] f;
    int r;
    pcm_in = '0; pcm_valid = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_delay = '0; cfg_commit = 1'b0; rst = 1'b0;
    edge_n = 0; free_edge = 0; hold_m = '0; pending_m = 0;
    checks = 0; failures = 0; mon_en = 0;
    tick();
    tick();
    rst = 1'b1;

    // Pass-through with all delays zero, lane c = c+1.
    for (int c = 0; c < CHANNELS; c++) f[c*DATA_W +: DATA_W] = DATA_W'(c + 1);
    send_frame(f);
    repeat (20) tick();

    // Delay c on lane c with priming zeros.
    do_reset();
    for (int c = 0; c < CHANNELS; c++) stage(c, c);
    commit();
    for (int n = 1; n <= 20; n++) send_frame(const_frame(n));

    // Out-of-range delay clamps to MAX_DELAY; frame counter saturates.
    for (int c = 0; c < CHANNELS; c++) stage(c, (c == 3) ? 100 : int'($urandom_range(0, 127)));
    commit();
    for (int n = 0; n < 70; n++) begin
      f = rand_frame();
      f[3*DATA_W +: DATA_W] = DATA_W'(n + 1000);
      send_frame(f);
    end

    // Overrun: second strobe five cycles after an accepted frame.
    send_frame(rand_frame());
    repeat (4) tick();
    pcm_in = rand_frame();
    pcm_valid = 1'b1;
    tick();
    send_frame(rand_frame());

    // Commit during PROC applies from the following frame only.
    for (int c = 0; c < CHANNELS; c++) stage(c, int'($urandom_range(0, 70)));
    send_frame(rand_frame());
    repeat (4) tick();
    commit();
    send_frame(rand_frame());
    send_frame(rand_frame());

    // Reset in the middle of PROC abandons the frame.
    send_frame(rand_frame());
    repeat (6) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send_frame(rand_frame());
    repeat (20) tick();

    // Random traffic, configuration and commits.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        pcm_in = rand_frame();
        pcm_valid = 1'b1;
      end else if (r < 6) begin
        cfg_we = 1'b1;
        cfg_ch = CH_W'($urandom);
        cfg_delay = (DELAY_W+1)'($urandom);
      end else if (r == 6) begin
        cfg_commit = 1'b1;
      end else if (r == 7) begin
        cfg_we = 1'b1;
        cfg_ch = CH_W'($urandom);
        cfg_delay = (DELAY_W+1)'($urandom);
        cfg_commit = 1'b1;
      end
      tick();
    end

    repeat (CHANNELS + 4) tick();
    chk("drain_empty", FW'(exp_q.size()), FW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
